// File: rtl/scct_counter_ctrl_pkg.sv
// Shared op codes, FSM state encoding and default widths for the scct counter access controller.
package scct_counter_ctrl_pkg;

    localparam int SCCT_COUNTER_CTR_WIDTH = 16;
    localparam int SCCT_COUNTER_PSC_WIDTH = 8;

    localparam logic [2:0] SCCT_OP_RD_CTR  = 3'd0;
    localparam logic [2:0] SCCT_OP_RD_CFG  = 3'd1;
    localparam logic [2:0] SCCT_OP_WR_IEN  = 3'd2;
    localparam logic [2:0] SCCT_OP_CLR_IRQ = 3'd3;
    localparam logic [2:0] SCCT_OP_WR_PSC  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } scct_state_e;

    function automatic logic scct_op_is_legal(input logic [2:0] op);
        return (op <= SCCT_OP_WR_PSC);
    endfunction

endpackage

// File: rtl/scct_counter_ctrl_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward from last+1, wrapping.
module scct_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    int cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!valid && req[IDX_W'(cand)]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/scct_counter_ctrl.sv
// Serialises register operations from NREQ requesters onto one scct_counter config/status port.
module scct_counter_ctrl
    import scct_counter_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CTR_W = SCCT_COUNTER_CTR_WIDTH,
    parameter int PSC_W = SCCT_COUNTER_PSC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [3*NREQ-1:0]     op_i,
    input  logic [PSC_W*NREQ-1:0] wdata_i,
    output logic [NREQ-1:0]       ack_o,
    output logic                  err_o,
    output logic [CTR_W-1:0]      rdata_o,
    output logic                  busy_o,
    input  logic [CTR_W-1:0]      counter_i,
    input  logic                  irq_enable_i,
    input  logic                  irq_status_i,
    input  logic [PSC_W-1:0]      prescaler_i,
    output logic                  irq_enable_o,
    output logic                  irq_enable_wen_o,
    output logic                  irq_status_o,
    output logic                  irq_status_wen_o,
    output logic [PSC_W-1:0]      prescaler_o,
    output logic                  prescaler_wen_o
);

    localparam int IDX_W = $clog2(NREQ);

    scct_state_e      state;
    scct_state_e      state_nxt;
    logic [IDX_W-1:0] last_q;
    logic             busy_q;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [2:0]       op_sel;
    logic [PSC_W-1:0] wdata_sel;

    logic [IDX_W-1:0] win_p1;
    logic [2:0]       op_p1;
    logic [PSC_W-1:0] wdata_p1;

    logic [CTR_W-1:0] rdata_nxt;
    logic [CTR_W-1:0] rdata_p2;
    logic             err_p2;

    scct_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_i),
        .last   (last_q),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    always_comb begin
        op_sel    = '0;
        wdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                op_sel    = op_i[3*i +: 3];
                wdata_sel = wdata_i[PSC_W*i +: PSC_W];
            end
        end
    end

    // Control state: async reset aborts any transaction and restores requester 0 as first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            last_q <= IDX_W'(NREQ - 1);
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            if (state == ST_ACK) begin
                last_q <= win_p1;
            end
        end
    end

    always_comb begin
        rdata_nxt = '0;
        case (op_p1)
            SCCT_OP_RD_CTR: rdata_nxt = counter_i;
            SCCT_OP_RD_CFG: rdata_nxt[PSC_W+1:0] = {irq_enable_i, irq_status_i, prescaler_i};
            default:        rdata_nxt = '0;
        endcase
    end

    // Stage p1: winner, op and wdata frozen at grant; stage p2: read data / error captured leaving ISSUE.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && pick_vld) begin
            win_p1   <= pick_idx;
            op_p1    <= op_sel;
            wdata_p1 <= wdata_sel;
        end
        if (state == ST_ISSUE) begin
            rdata_p2 <= rdata_nxt;
            err_p2   <= !scct_op_is_legal(op_p1);
        end
    end

    always_comb begin
        state_nxt        = state;
        ack_o            = '0;
        err_o            = 1'b0;
        rdata_o          = '0;
        irq_enable_o     = 1'b0;
        irq_enable_wen_o = 1'b0;
        irq_status_o     = 1'b0;
        irq_status_wen_o = 1'b0;
        prescaler_o      = '0;
        prescaler_wen_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_ACK;
                case (op_p1)
                    SCCT_OP_WR_IEN: begin
                        irq_enable_wen_o = 1'b1;
                        irq_enable_o     = wdata_p1[0];
                    end
                    SCCT_OP_CLR_IRQ: begin
                        irq_status_wen_o = 1'b1;
                        irq_status_o     = 1'b1;
                    end
                    SCCT_OP_WR_PSC: begin
                        prescaler_wen_o = 1'b1;
                        prescaler_o     = wdata_p1;
                    end
                    default: ;
                endcase
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
                ack_o     = NREQ'(1) << win_p1;
                err_o     = err_p2;
                rdata_o   = rdata_p2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_scct_counter_ctrl.sv
// Bench for scct_counter_ctrl with a behavioural stand-in for the scct_counter register file.
module tb_scct_counter_ctrl;

    localparam int NREQ  = 4;
    localparam int CTR_W = 10;
    localparam int PSC_W = 4;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     op;
    logic [PSC_W*NREQ-1:0] wd;

    logic [NREQ-1:0]  ack_o;
    logic             err_o;
    logic [CTR_W-1:0] rdata_o;
    logic             busy_o;
    logic             irq_enable_o, irq_enable_wen_o, irq_status_o, irq_status_wen_o;
    logic [PSC_W-1:0] prescaler_o;
    logic             prescaler_wen_o;

    logic [CTR_W-1:0] ctr;
    logic             cm_ien, cm_st, cm_clr;
    logic [PSC_W-1:0] cm_psc;
    logic [PSC_W+4:0] ctl_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl_out = {irq_enable_wen_o, irq_enable_o, irq_status_wen_o, irq_status_o,
                      prescaler_wen_o, prescaler_o};

    scct_counter_ctrl #(.NREQ(NREQ), .CTR_W(CTR_W), .PSC_W(PSC_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .op_i(op), .wdata_i(wd),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .counter_i(ctr), .irq_enable_i(cm_ien), .irq_status_i(cm_st), .prescaler_i(cm_psc),
        .irq_enable_o(irq_enable_o), .irq_enable_wen_o(irq_enable_wen_o),
        .irq_status_o(irq_status_o), .irq_status_wen_o(irq_status_wen_o),
        .prescaler_o(prescaler_o), .prescaler_wen_o(prescaler_wen_o)
    );

    // Counter stand-in: free-running count, overflow sets status and beats a same-cycle clear.
    always @(posedge clk) begin
        if (cm_clr) begin
            ctr <= '0; cm_ien <= 1'b0; cm_st <= 1'b0; cm_psc <= '0;
        end else begin
            ctr <= ctr + 1'b1;
            if (irq_enable_wen_o) cm_ien <= irq_enable_o;
            if (prescaler_wen_o) cm_psc <= prescaler_o;
            if (ctr == CTR_MAX && cm_ien) cm_st <= 1'b1;
            else if (irq_status_wen_o && irq_status_o) cm_st <= 1'b0;
        end
    end

    function automatic logic [CTR_W-1:0] cfg_word(input logic ien, input logic st, input logic [PSC_W-1:0] psc);
        logic [CTR_W-1:0] v;
        v = '0;
        v[PSC_W+1:0] = {ien, st, psc};
        return v;
    endfunction

    // Drives one request from an idle point and records what the DUT did until its ack.
    task automatic run_op(input int idx, input logic [2:0] o, input logic [PSC_W-1:0] w,
                          output int lat, output logic [NREQ-1:0] ack, output logic er,
                          output logic [CTR_W-1:0] rd, output int wen_cnt,
                          output logic [PSC_W-1:0] psc_seen);
        lat = -1; ack = '0; er = 1'b0; rd = '0; wen_cnt = 0; psc_seen = '0;
        @(negedge clk);
        req[idx] = 1'b1;
        op[3*idx +: 3] = o;
        wd[PSC_W*idx +: PSC_W] = w;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (irq_enable_wen_o || irq_status_wen_o || prescaler_wen_o) begin
                wen_cnt++;
                if (prescaler_wen_o) psc_seen = prescaler_o;
            end
            if (ack_o != '0) begin
                lat = c; ack = ack_o; er = err_o; rd = rdata_o;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic ctrl_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; op = '0; wd = '0;
        rst_n = 1'b0; cm_clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_o, err_o, busy_o} !== '0) begin
            failures++; $display("FAIL reset_ack_busy: got %0h required 0", {ack_o, err_o, busy_o});
        end
        checks++;
        if (rdata_o !== '0 || ctl_out !== '0) begin
            failures++; $display("FAIL reset_data: rdata %0h ctl %0h required 0", rdata_o, ctl_out);
        end
        rst_n = 1'b1; cm_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack_o, busy_o, ctl_out} !== '0) begin
            failures++; $display("FAIL idle_after_reset: got %0h required 0", {ack_o, busy_o, ctl_out});
        end
    endtask

    task automatic test_wr_psc();
        int lat, wc; logic [NREQ-1:0] ack; logic er; logic [CTR_W-1:0] rd; logic [PSC_W-1:0] ps;
        run_op(0, 3'd4, 4'd5, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b0001 || lat != 2) begin
            failures++; $display("FAIL psc_ack: ack %b lat %0d required 0001 lat 2", ack, lat);
        end
        checks++;
        if (wc != 1 || ps !== 4'd5) begin
            failures++; $display("FAIL psc_wen: pulses %0d value %0d required 1 pulse value 5", wc, ps);
        end
        checks++;
        if (er !== 1'b0 || rd !== '0) begin
            failures++; $display("FAIL psc_err_rdata: err %b rdata %0h required 0 0", er, rd);
        end
        run_op(0, 3'd1, 4'd0, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b0001 || rd !== cfg_word(1'b0, 1'b0, 4'd5) || wc != 0) begin
            failures++; $display("FAIL rd_cfg_psc: ack %b rdata %0h wen %0d required 0001 %0h 0",
                                 ack, rd, wc, cfg_word(1'b0, 1'b0, 4'd5));
        end
    endtask

    task automatic test_round_robin();
        int got, last_cyc;
        ctrl_reset();
        req = '1; op = '0;
        got = 0; last_cyc = 0;
        for (int c = 1; c <= 40 && got < 5; c++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                checks++;
                if (ack_o !== (4'b0001 << (got % NREQ)) || rdata_o !== CTR_W'(ctr - 1'b1)) begin
                    failures++;
                    $display("FAIL rr_order_%0d: ack %b rdata %0h required %b %0h", got, ack_o, rdata_o,
                             4'b0001 << (got % NREQ), CTR_W'(ctr - 1'b1));
                end
                checks++;
                if ((got == 0 && c != 2) || (got > 0 && c - last_cyc != 3)) begin
                    failures++; $display("FAIL rr_spacing_%0d: cycle %0d previous %0d", got, c, last_cyc);
                end
                last_cyc = c;
                got++;
            end
        end
        req = '0;
        checks++;
        if (got != 5) begin
            failures++; $display("FAIL rr_count: got %0d acks required 5", got);
        end
    endtask

    task automatic test_irq_overflow();
        int lat, wc; logic [NREQ-1:0] ack; logic er; logic [CTR_W-1:0] rd; logic [PSC_W-1:0] ps;
        logic found;
        run_op(0, 3'd2, 4'd1, lat, ack, er, rd, wc, ps);
        run_op(1, 3'd3, 4'd0, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b0010 || er !== 1'b0 || wc != 1) begin
            failures++; $display("FAIL clr_irq_ack: ack %b err %b wen %0d required 0010 0 1", ack, er, wc);
        end
        run_op(3, 3'd1, 4'd0, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b1000 || rd !== cfg_word(1'b1, 1'b0, 4'd5)) begin
            failures++; $display("FAIL cfg_after_clear: ack %b rdata %0h required 1000 %0h",
                                 ack, rd, cfg_word(1'b1, 1'b0, 4'd5));
        end
        found = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (ctr == CTR_MAX - 2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL overflow_wait: counter never reached %0h", CTR_MAX - 2);
        end
        run_op(0, 3'd3, 4'd0, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b0001 || er !== 1'b0) begin
            failures++; $display("FAIL clr_at_overflow: ack %b err %b required 0001 0", ack, er);
        end
        run_op(2, 3'd1, 4'd0, lat, ack, er, rd, wc, ps);
        checks++;
        if (rd !== cfg_word(1'b1, 1'b1, 4'd5)) begin
            failures++; $display("FAIL status_after_overflow: rdata %0h required %0h", rd, cfg_word(1'b1, 1'b1, 4'd5));
        end
    endtask

    task automatic test_illegal();
        int lat, wc; logic [NREQ-1:0] ack; logic er; logic [CTR_W-1:0] rd; logic [PSC_W-1:0] ps;
        run_op(2, 3'd6, 4'd15, lat, ack, er, rd, wc, ps);
        checks++;
        if (ack !== 4'b0100 || er !== 1'b1) begin
            failures++; $display("FAIL illegal_ack: ack %b err %b required 0100 1", ack, er);
        end
        checks++;
        if (wc != 0 || rd !== '0) begin
            failures++; $display("FAIL illegal_side: wen %0d rdata %0h required 0 0", wc, rd);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        @(negedge clk);
        req[0] = 1'b1; op[2:0] = 3'd2; wd[PSC_W-1:0] = 4'd0;
        @(negedge clk);
        checks++;
        if (irq_enable_wen_o !== 1'b1 || irq_enable_o !== 1'b0) begin
            failures++; $display("FAIL mid_issue_wen: wen %b data %b required 1 0", irq_enable_wen_o, irq_enable_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ctl_out !== '0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_drop: ctl %0h busy %b required 0 0", ctl_out, busy_o);
        end
        req = '0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack_o != '0 || ctl_out != '0) acks++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack_o != '0 || ctl_out != '0) acks++;
        end
        checks++;
        if (acks != 0 || cm_ien !== 1'b1) begin
            failures++; $display("FAIL mid_reset_abort: stray cycles %0d ien %b required 0 1", acks, cm_ien);
        end
        req[1] = 1'b1; op[5:3] = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_o !== 4'b0010) begin
            failures++; $display("FAIL req1_alone_after_reset: ack %b required 0010", ack_o);
        end
        req = '0;
        ctrl_reset();
        req = 4'b0011; op = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_o !== 4'b0001) begin
            failures++; $display("FAIL req0_first_after_reset: ack %b required 0001", ack_o);
        end
        req = '0;
    endtask

    task automatic test_cancel();
        int seen1;
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b1; op[2:0] = 3'd0;
        @(negedge clk);
        req[1] = 1'b1; op[5:3] = 3'd1;
        @(negedge clk);
        checks++;
        if (ack_o !== 4'b0001) begin
            failures++; $display("FAIL cancel_req0_ack: ack %b required 0001", ack_o);
        end
        req = '0;
        seen1 = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_o != '0) seen1++;
        end
        checks++;
        if (seen1 != 0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL cancel_req1: acks %0d busy %b required 0 0", seen1, busy_o);
        end
    endtask

    // Transaction-level model: rr winner from pending set, 3-cycle occupancy, shadow config registers.
    task automatic test_random();
        logic [NREQ-1:0]  pend;
        logic [2:0]       mop [NREQ];
        logic [PSC_W-1:0] mwd [NREQ];
        logic [2:0]       t_op;
        logic [PSC_W-1:0] t_wd;
        logic [PSC_W+4:0] exp_ctl;
        logic [CTR_W-1:0] exp_rd;
        logic             sh_ien, sh_st;
        logic [PSC_W-1:0] sh_psc;
        int m_last, win, pos;
        @(negedge clk);
        rst_n = 1'b0; cm_clr = 1'b1; req = '0;
        @(negedge clk);
        rst_n = 1'b1; cm_clr = 1'b0;
        pend = '0; m_last = NREQ - 1; win = 0; pos = 0;
        sh_ien = 1'b0; sh_st = 1'b0; sh_psc = '0;
        t_op = '0; t_wd = '0;
        for (int i = 0; i < NREQ; i++) begin mop[i] = '0; mwd[i] = '0; end
        for (int cyc = 0; cyc < 260; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (cyc < 200 && !pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    mop[i] = 3'($urandom_range(0, 7));
                    mwd[i] = PSC_W'($urandom);
                end
                req[i] = pend[i];
                op[3*i +: 3] = mop[i];
                wd[PSC_W*i +: PSC_W] = mwd[i];
            end
            if (pos == 0 && pend != '0) begin
                win = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (win < 0 && pend[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
                end
                t_op = mop[win]; t_wd = mwd[win];
                pos = 1;
            end else if (pos == 1) begin
                pos = 2;
            end else begin
                pos = 0;
            end
            @(negedge clk);
            if (pos == 1) begin
                exp_ctl = '0;
                if (t_op == 3'd2) begin exp_ctl[PSC_W+4] = 1'b1; exp_ctl[PSC_W+3] = t_wd[0]; end
                if (t_op == 3'd3) begin exp_ctl[PSC_W+2] = 1'b1; exp_ctl[PSC_W+1] = 1'b1; end
                if (t_op == 3'd4) begin exp_ctl[PSC_W] = 1'b1; exp_ctl[PSC_W-1:0] = t_wd; end
                checks++;
                if (ctl_out !== exp_ctl || ack_o !== '0 || busy_o !== 1'b1) begin
                    failures++; $display("FAIL rnd_issue cyc %0d op %0d: ctl %0h ack %b busy %b required %0h 0000 1",
                                         cyc, t_op, ctl_out, ack_o, busy_o, exp_ctl);
                end
            end else if (pos == 2) begin
                exp_rd = '0;
                if (t_op == 3'd0) exp_rd = CTR_W'(ctr - 1'b1);
                if (t_op == 3'd1) exp_rd = cfg_word(sh_ien, sh_st, sh_psc);
                checks++;
                if (ack_o !== (NREQ'(1) << win) || err_o !== (t_op > 3'd4) || rdata_o !== exp_rd || busy_o !== 1'b1) begin
                    failures++; $display("FAIL rnd_ack cyc %0d op %0d: ack %b err %b rdata %0h required %b %b %0h",
                                         cyc, t_op, ack_o, err_o, rdata_o, NREQ'(1) << win, t_op > 3'd4, exp_rd);
                end
                if (t_op == 3'd2) sh_ien = t_wd[0];
                if (t_op == 3'd3) sh_st = 1'b0;
                if (t_op == 3'd4) sh_psc = t_wd;
                pend[win] = 1'b0;
                m_last = win;
            end else begin
                checks++;
                if (ack_o !== '0 || busy_o !== 1'b0 || ctl_out !== '0) begin
                    failures++; $display("FAIL rnd_idle cyc %0d: ack %b busy %b ctl %0h required 0", cyc, ack_o, busy_o, ctl_out);
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_wr_psc();
        test_round_robin();
        test_irq_overflow();
        test_illegal();
        test_reset_mid();
        test_cancel();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
